// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO, its read-side stream interface and the
// fifo_stream_reader drain controller.
//   FIFO_WIDTH_DEFAULT / FIFO_DEPTH_DEFAULT : default FIFO geometry
//   RD_BUF_DEPTH                            : entries in the reader output buffer
//   reader_state_t                          : reader controller states
//   buf_ptr_inc()                           : wrapping pointer increment for that buffer
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_WIDTH_DEFAULT = 16;
    localparam int FIFO_DEPTH_DEFAULT = 16;
    localparam int RD_BUF_DEPTH       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

    // The buffer depth is not a power of two, so pointers wrap explicitly.
    function automatic logic [1:0] buf_ptr_inc(input logic [1:0] p);
        return (p == 2'(RD_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader_if
// Bundles the two handshakes of the reader: the FIFO read port and the
// outgoing valid/ready stream.
//   FIFO side  : rd_en (reader->FIFO), empty, data_out, underflow (FIFO->reader)
//   Stream side: out_data, out_valid, out_last (reader->sink), out_ready (sink->reader)
// Modports: master = the reader, slave = the FIFO plus the sink.
// FIFO_WIDTH must match the FIFO_WIDTH of the reader bound to this instance.
// ---------------------------------------------------------------------------
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEFAULT
);

    logic                  rd_en;
    logic                  empty;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  underflow;
    logic [FIFO_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output rd_en,
        input  empty,
        input  data_out,
        input  underflow,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last
    );

    modport slave (
        input  rd_en,
        output empty,
        output data_out,
        output underflow,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last
    );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// ---------------------------------------------------------------------------
// stream_skid_buf
// Small circular buffer that absorbs the FIFO read latency in front of the
// output stream.
//   clk, rst_n  : clock, synchronous active-low reset
//   i_push      : write i_push_data into the tail
//   i_pop       : drop the head entry (ignored when empty)
//   o_occ       : number of stored entries (0..RD_BUF_DEPTH)
//   o_head      : oldest entry, forced to zero while empty
// ---------------------------------------------------------------------------
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEFAULT
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [1:0]       o_occ,
    output logic [WIDTH-1:0] o_head
);

    localparam logic [1:0] OCC_FULL = 2'(RD_BUF_DEPTH);

    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_rd_ptr;
    logic [1:0]       r_occ;
    logic [WIDTH-1:0] w_entries [RD_BUF_DEPTH];
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_occ != 2'd0);
    // The reader's issue rule never overfills the buffer; a push into a
    // full buffer without a simultaneous pop is refused rather than
    // overwriting the head.
    assign w_push = i_push && ((r_occ != OCC_FULL) || w_pop);

    genvar gi;
    generate
        for (gi = 0; gi < RD_BUF_DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] r_entry;
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == 2'(gi))) begin
                    r_entry <= i_push_data;
                end
            end
            assign w_entries[gi] = r_entry;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= buf_ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= buf_ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    // Entries are not reset, so the head is masked to keep out_data at zero
    // after reset and whenever nothing is buffered.
    assign o_head = (r_occ != 2'd0) ? w_entries[r_rd_ptr] : '0;

endmodule

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
// Read-side drain controller placed directly after a FIFO. Issues rd_en,
// captures the word the FIFO returns one cycle later into a 3-entry buffer
// and presents it as a valid/ready stream with frame-end markers.
//   clk, rst_n     : clock, synchronous active-low reset (shared with the FIFO)
//   en             : run request
//   bus (master)   : FIFO read port + output stream (see fifo_stream_reader_if)
//   busy           : controller not idle
//   word_cnt       : output handshakes since reset, wrapping
//   err_underflow  : sticky FIFO underflow flag, cleared by clr_err
//   clr_err        : clear for err_underflow (a coincident underflow wins)
// ---------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
    parameter int FRAME_LEN  = 8,
    parameter int CNT_WIDTH  = 16
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    fifo_stream_reader_if.master   bus,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   word_cnt,
    output logic                   err_underflow,
    input  logic                   clr_err
);

    localparam int                BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);

    reader_state_t         r_state;
    logic                  r_inflight;
    logic [BEAT_W-1:0]     r_beat;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic                  r_err;

    logic [1:0]            w_occ;
    logic [FIFO_WIDTH-1:0] w_head;
    logic [2:0]            w_pending;
    logic                  w_rd_en;
    logic                  w_valid;
    logic                  w_hs;

    // Words already buffered plus the one the FIFO is about to return.
    assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight};

    // Reads depend only on registered state and empty; out_ready has no
    // path here, so a read is issued only when a slot is guaranteed free.
    assign w_rd_en = rst_n && (r_state == RUN) && !bus.empty
                     && (w_pending < 3'(RD_BUF_DEPTH));

    assign w_valid = (w_occ != 2'd0);
    assign w_hs    = w_valid && bus.out_ready;

    stream_skid_buf #(
        .WIDTH       (FIFO_WIDTH)
    ) u_skid_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (bus.data_out),
        .i_pop       (w_hs),
        .o_occ       (w_occ),
        .o_head      (w_head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_inflight <= 1'b0;
            r_beat     <= '0;
            r_word_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;

            // Frame position is deliberately kept across DRAIN/IDLE.
            if (w_hs) begin
                r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
                r_beat     <= (r_beat == BEAT_LAST) ? '0 : r_beat + BEAT_W'(1);
            end

            if (bus.underflow)  r_err <= 1'b1;
            else if (clr_err)   r_err <= 1'b0;

            case (r_state)
                IDLE:    if (en) r_state <= RUN;
                RUN:     if (!en) r_state <= DRAIN;
                DRAIN: begin
                    if (en)                                  r_state <= RUN;
                    else if ((w_occ == 2'd0) && !r_inflight) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rd_en     = w_rd_en;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_head;
    assign bus.out_last  = w_valid && (r_beat == BEAT_LAST);
    assign busy          = (r_state != IDLE);
    assign word_cnt      = r_word_cnt;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
// Drives fifo_stream_reader from a behavioural FIFO and a sink, and compares
// the delivered stream with the order words were written to the FIFO.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int W  = 16;
    localparam int FL = 8;
    localparam int CW = 16;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          en      = 1'b0;
    logic          clr_err = 1'b0;
    logic          busy;
    logic [CW-1:0] word_cnt;
    logic          err_underflow;

    fifo_stream_reader_if #(.FIFO_WIDTH(W)) bus ();

    fifo_stream_reader #(
        .FIFO_WIDTH    (W),
        .FRAME_LEN     (FL),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .bus           (bus),
        .busy          (busy),
        .word_cnt      (word_cnt),
        .err_underflow (err_underflow),
        .clr_err       (clr_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural FIFO ----------------
    logic [W-1:0] fmem [1024];
    int unsigned  wr_idx = 0;
    int unsigned  rd_idx = 0;

    assign bus.empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (!rst_n) begin
            rd_idx <= wr_idx;
        end else if (bus.rd_en && (rd_idx != wr_idx)) begin
            bus.data_out <= fmem[rd_idx % 1024];
            rd_idx       <= rd_idx + 1;
        end
    end

    // ---------------- reference model / recording ----------------
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q [$];     // words written to the FIFO, not yet delivered
    logic [W-1:0] got_data [$];
    logic         got_last [$];
    int           hs_cyc [$];
    int           rd_cyc [$];
    int           rd_total = 0;
    int           hs_total = 0;
    int           cyc_no = 0;
    int           viol = 0;
    int           stall_viol = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;

    task automatic push_word(input logic [W-1:0] w);
        fmem[wr_idx % 1024] = w;
        wr_idx = wr_idx + 1;
        exp_q.push_back(w);
    endtask

    task automatic clear_rec();
        got_data.delete(); got_last.delete(); hs_cyc.delete(); rd_cyc.delete();
        rd_total = 0; viol = 0; stall_viol = 0; prev_stall = 1'b0;
    endtask

    // Records what will happen at the coming rising edge (inputs are stable).
    task automatic observe();
        cyc_no++;
        if (bus.rd_en && bus.empty) viol++;
        if (bus.rd_en) begin rd_total++; rd_cyc.push_back(cyc_no); end
        if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
            stall_viol++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
        if (bus.out_valid && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_last.push_back(bus.out_last);
            hs_cyc.push_back(cyc_no);
            hs_total++;
        end
    endtask

    task automatic run_cycle();
        #1; observe();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; bus.out_ready = 1'b0; bus.underflow = 1'b0; clr_err = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete(); hs_total = 0;
        clear_rec();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; bus.out_ready = 1'b1;
        push_word(16'hABCD);
        #1;
        checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus.rd_en); end
        @(negedge clk); @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_underflow); end
        checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en_held: got %b want 0", bus.rd_en); end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0; bus.out_ready = 1'b0;
        exp_q.delete(); hs_total = 0; clear_rec();
        $display("test_reset done");
    endtask

    task automatic test_stream();
        int c0, bad_d, bad_l;
        logic [W-1:0] e;
        do_reset();
        for (int w = 1; w <= 8; w++) push_word(W'(w));
        en = 1'b1; bus.out_ready = 1'b1;
        c0 = cyc_no + 1;
        for (int i = 0; i < 20; i++) run_cycle();
        checks++; if (rd_total != 8) begin errors++; $display("FAIL stream_rd_count: got %0d want 8", rd_total); end
        if (rd_cyc.size() == 8) begin
            checks++; if (rd_cyc[0] != c0 + 1) begin errors++; $display("FAIL stream_first_rd: got cycle %0d want %0d", rd_cyc[0], c0 + 1); end
            checks++; if (rd_cyc[7] - rd_cyc[0] != 7) begin errors++; $display("FAIL stream_rd_consec: got span %0d want 7", rd_cyc[7] - rd_cyc[0]); end
        end
        checks++; if (got_data.size() != 8) begin errors++; $display("FAIL stream_words: got %0d want 8", got_data.size()); end
        if (hs_cyc.size() == 8) begin
            checks++; if (hs_cyc[0] != c0 + 3) begin errors++; $display("FAIL stream_first_valid: got cycle %0d want %0d", hs_cyc[0], c0 + 3); end
            checks++; if (hs_cyc[7] - hs_cyc[0] != 7) begin errors++; $display("FAIL stream_throughput: got span %0d want 7", hs_cyc[7] - hs_cyc[0]); end
        end
        bad_d = 0; bad_l = 0;
        foreach (got_data[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            if (got_data[i] !== e) bad_d++;
            if (got_last[i] !== ((i % FL) == FL - 1)) bad_l++;
        end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL stream_order: got %0d bad words want 0", bad_d); end
        checks++; if (bad_l != 0) begin errors++; $display("FAIL stream_last: got %0d bad last flags want 0", bad_l); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle();
        #1;
        checks++; if (word_cnt !== 16'd8) begin errors++; $display("FAIL stream_word_cnt: got %0d want 8", word_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_idle: got busy %b want 0", busy); end
        @(negedge clk);
        $display("test_stream done: %0d words", got_data.size());
    endtask

    task automatic test_stall();
        int bad_hold, valid_cyc, bad_d;
        logic [W-1:0] e;
        do_reset();
        for (int w = 1; w <= 8; w++) push_word(W'(w));
        en = 1'b1; bus.out_ready = 1'b0;
        bad_hold = 0; valid_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            #1; observe();
            if (bus.out_valid) begin
                valid_cyc++;
                if (bus.out_data !== 16'h0001) bad_hold++;
            end
            @(negedge clk);
        end
        checks++; if (rd_total != 3) begin errors++; $display("FAIL stall_reads: got %0d want 3", rd_total); end
        checks++; if (valid_cyc != 7) begin errors++; $display("FAIL stall_valid_cycles: got %0d want 7", valid_cyc); end
        checks++; if (bad_hold != 0) begin errors++; $display("FAIL stall_hold_0001: got %0d bad cycles want 0", bad_hold); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) run_cycle();
        checks++; if (got_data.size() != 8) begin errors++; $display("FAIL stall_words: got %0d want 8", got_data.size()); end
        bad_d = 0;
        foreach (got_data[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            if (got_data[i] !== e) bad_d++;
        end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL stall_order: got %0d bad words want 0", bad_d); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stability: got %0d changes want 0", stall_viol); end
        en = 1'b0;
        run_cycle(); run_cycle();
        $display("test_stall done: %0d words", got_data.size());
    endtask

    task automatic test_empty();
        int busy_bad, err_bad;
        do_reset();
        en = 1'b1; bus.out_ready = 1'b1;
        busy_bad = 0; err_bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1; observe();
            if (i > 0 && busy !== 1'b1) busy_bad++;
            if (err_underflow !== 1'b0) err_bad++;
            @(negedge clk);
        end
        checks++; if (rd_total != 0) begin errors++; $display("FAIL empty_rd_en: got %0d reads want 0", rd_total); end
        checks++; if (viol != 0) begin errors++; $display("FAIL empty_read_of_empty: got %0d want 0", viol); end
        checks++; if (err_bad != 0) begin errors++; $display("FAIL empty_err: got %0d set cycles want 0", err_bad); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL empty_busy: got %0d idle cycles want 0", busy_bad); end
        en = 1'b0;
        run_cycle(); run_cycle();
        $display("test_empty done");
    endtask

    task automatic test_drain();
        int k, bad_d, bad_l, drain_busy;
        logic [W-1:0] e;
        do_reset();
        for (int w = 1; w <= 8; w++) push_word(W'(16'h0010 + w));
        en = 1'b1; bus.out_ready = 1'b0;
        k = 0;
        while (rd_total < 3 && k < 20) begin run_cycle(); k++; end
        checks++; if (rd_total != 3) begin errors++; $display("FAIL drain_setup_reads: got %0d want 3", rd_total); end
        // two words buffered, one inflight
        en = 1'b0; bus.out_ready = 1'b1;
        drain_busy = 0;
        for (int i = 0; i < 12; i++) begin
            #1; observe();
            if (i == 1) drain_busy = busy;
            @(negedge clk);
        end
        checks++; if (drain_busy != 1) begin errors++; $display("FAIL drain_busy: got %0d want 1", drain_busy); end
        checks++; if (rd_total != 3) begin errors++; $display("FAIL drain_no_reads: got %0d want 3", rd_total); end
        checks++; if (got_data.size() != 3) begin errors++; $display("FAIL drain_words: got %0d want 3", got_data.size()); end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_idle: got busy %b want 0", busy); end
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 20; i++) run_cycle();
        checks++; if (got_data.size() != 8) begin errors++; $display("FAIL drain_resume_words: got %0d want 8", got_data.size()); end
        bad_d = 0; bad_l = 0;
        foreach (got_data[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            if (got_data[i] !== e) bad_d++;
            if (got_last[i] !== (i == 7)) bad_l++;
        end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL drain_order: got %0d bad words want 0", bad_d); end
        checks++; if (bad_l != 0) begin errors++; $display("FAIL drain_beat_kept: got %0d bad last flags want 0", bad_l); end
        en = 1'b0;
        run_cycle(); run_cycle();
        $display("test_drain done: %0d words", got_data.size());
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int w = 1; w <= 8; w++) push_word(W'(16'h0020 + w));
        en = 1'b1; bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle();
        // buffer holds two words now
        rst_n = 1'b0; bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_setup_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("FAIL midrst_rd_en: got %b want 0", bus.rd_en); end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
        exp_q.delete(); hs_total = 0; clear_rec();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL midrst_word_cnt: got %0d want 0", word_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        @(negedge clk);
        push_word(16'h0100); push_word(16'h0101);
        en = 1'b1;
        for (int i = 0; i < 10; i++) run_cycle();
        checks++; if (got_data.size() != 2) begin errors++; $display("FAIL midrst_words: got %0d want 2", got_data.size()); end
        if (got_data.size() == 2) begin
            checks++; if (got_data[0] !== 16'h0100 || got_data[1] !== 16'h0101) begin
                errors++; $display("FAIL midrst_data: got %h %h want 0100 0101", got_data[0], got_data[1]);
            end
        end
        en = 1'b0;
        run_cycle(); run_cycle();
        $display("test_reset_mid done");
    endtask

    task automatic test_underflow();
        do_reset();
        #1;
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_initial: got %b want 0", err_underflow); end
        @(negedge clk);
        bus.underflow = 1'b1;
        @(negedge clk);
        bus.underflow = 1'b0;
        #1;
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b want 1", err_underflow); end
        for (int i = 0; i < 5; i++) @(negedge clk);
        #1;
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
        @(negedge clk);
        clr_err = 1'b1; bus.underflow = 1'b1;
        @(negedge clk);
        clr_err = 1'b0; bus.underflow = 1'b0;
        #1;
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins: got %b want 1", err_underflow); end
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b want 0", err_underflow); end
        @(negedge clk);
        $display("test_underflow done");
    endtask

    task automatic test_random();
        int pushed, bad_d, bad_l;
        logic [W-1:0] e;
        do_reset();
        pushed = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 1) == 1) begin push_word(W'($urandom)); pushed++; end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 15) != 0);
            run_cycle();
        end
        en = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 150; i++) run_cycle();
        en = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle();
        checks++; if (got_data.size() != pushed) begin errors++; $display("FAIL rand_words: got %0d want %0d", got_data.size(), pushed); end
        bad_d = 0; bad_l = 0;
        foreach (got_data[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            if (got_data[i] !== e) bad_d++;
            if (got_last[i] !== ((i % FL) == FL - 1)) bad_l++;
        end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL rand_order: got %0d bad words want 0", bad_d); end
        checks++; if (bad_l != 0) begin errors++; $display("FAIL rand_last: got %0d bad last flags want 0", bad_l); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand_stall_stability: got %0d changes want 0", stall_viol); end
        checks++; if (viol != 0) begin errors++; $display("FAIL rand_read_of_empty: got %0d want 0", viol); end
        #1;
        checks++; if (word_cnt !== CW'(hs_total)) begin errors++; $display("FAIL rand_word_cnt: got %0d want %0d", word_cnt, hs_total); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle: got busy %b want 0", busy); end
        @(negedge clk);
        $display("test_random done: %0d pushed, %0d delivered", pushed, got_data.size());
    endtask

    initial begin
        bus.out_ready = 1'b0;
        bus.underflow = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_empty();
        test_drain();
        test_reset_mid();
        test_underflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain controller that sits directly downstream of the FIFO. It issues `rd_en` to the FIFO, absorbs the FIFO's one-cycle read latency in a 3-entry output buffer, and presents the words as a valid/ready stream with frame markers. It never reads an empty FIFO, and it sustains one word per cycle when the sink is always ready.

## Interface
Parameters:
- `FIFO_WIDTH`, default 16: data word width; must match the FIFO.
- `FRAME_LEN`, default 8: words per frame; `out_last` marks the final word of each frame; legal range ≥1.
- `CNT_WIDTH`, default 16: width of `word_cnt`.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `en`  in  1: run request.
- `empty`  in  1: FIFO empty flag.
- `data_out`  in  FIFO_WIDTH: FIFO read data.
- `underflow`  in  1: FIFO underflow flag.
- `rd_en`  out  1: FIFO read strobe.
- `out_data`  out  FIFO_WIDTH: stream data.
- `out_valid`  out  1: stream valid.
- `out_ready`  in  1: stream ready from the sink.
- `out_last`  out  1: last word of the current frame.
- `busy`  out  1: controller not idle.
- `word_cnt`  out  CNT_WIDTH: output handshakes since reset; wraps.
- `err_underflow`  out  1: sticky FIFO-underflow error.
- `clr_err`  in  1: clears `err_underflow`.

## Operation
- FIFO contract:
  - `rd_en` is sampled at an edge while `empty`=0.
  - `data_out` holds that word throughout the following cycle.
- Internal tracking:
  - `inflight` (0/1): set at an edge where `rd_en`=1; cleared at the next edge, when `data_out` is captured into the buffer.
  - `occ` (0..3): buffer occupancy.
- Read issue rule: `rd_en` = `rst_n` && (state==RUN) && !`empty` && (`occ` + `inflight` < 3).
  - The rule is combinational from registered state and `empty` only.
  - `out_ready` has no path to `rd_en`.
- State machine (`busy` = state != IDLE):
  - IDLE → RUN when `en`=1.
  - RUN → DRAIN when `en`=0.
  - DRAIN: no new reads; buffered and inflight words are still delivered.
  - DRAIN → RUN if `en`=1.
  - DRAIN → IDLE when `occ`=0, `inflight`=0 and no capture is pending.
- Output stream:
  - `out_valid` = (`occ` > 0); `out_data` = the oldest buffered word.
  - A handshake is `out_valid` && `out_ready`; it pops one entry.
  - Capture and pop in the same edge leave `occ` unchanged.
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- Frame counter `beat` (0..FRAME_LEN-1):
  - Increments on each handshake and wraps to 0 after FRAME_LEN-1.
  - `out_last` = `out_valid` && (`beat`==FRAME_LEN-1).
  - Not cleared by `en`; frame position survives DRAIN/IDLE. With FRAME_LEN=1, every word is last.
- `word_cnt`: increments by 1 on each handshake, modulo 2^CNT_WIDTH.
- `err_underflow`:
  - Set at any edge where `underflow`=1.
  - `clr_err` clears it; if set and clear coincide, set wins.
  - It is a protocol-violation detector: with a correct FIFO, the read issue rule keeps it at 0.

## Timing
- Reset values (edge with `rst_n`=0):
  - state IDLE; `occ`, `inflight`, `beat`, `word_cnt` = 0.
  - `err_underflow`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0.
  - `rd_en`=0 combinationally while `rst_n`=0.
- Reset mid-operation: buffered and inflight words are discarded; the FIFO is reset by the same `rst_n`.
- Latency: `rd_en` high in cycle c → FIFO data valid in c+1 → `out_valid` with that word in c+2.
- First read: `en` rises in cycle e (FIFO non-empty) → RUN from e+1 → `rd_en` in e+1 → first `out_valid` in e+3.
- Throughput: with `out_ready` held at 1 and the FIFO non-empty, steady state is `occ`=1, `inflight`=1, one word per cycle.
- Sink stall: `rd_en` stops once `occ` + `inflight` = 3; no word is lost or duplicated.
- FIFO runs empty mid-stream: `rd_en` drops in the same cycle `empty`=1; issue resumes in the cycle `empty` returns to 0.

## Structure
- Shared package `fifo_pkg`:
  - `FIFO_WIDTH`/`FIFO_DEPTH` defaults, shared with the FIFO and its interface.
  - `reader_state_t` enum {IDLE, RUN, DRAIN}.
  - Localparam `RD_BUF_DEPTH`=3.
- Sub-module `stream_skid_buf`: 3-entry circular buffer with push, pop, `occ` and head data.
- The top level holds the FSM, the issue rule, `inflight`, `beat`, `word_cnt` and the error flag.

## Test plan
- Reset, then preload FIFO with 8 words 0x0001..0x0008, `en`=1, `out_ready`=1:
  - `rd_en` is high for 8 consecutive cycles, then low.
  - Words appear in order on 8 consecutive cycles; `out_last` is set on 0x0008; `word_cnt`=8.
- Same preload, `out_ready`=0 for 10 cycles, then 1:
  - Exactly 3 reads are issued before `rd_en` stops.
  - `out_data` holds 0x0001 throughout the stall.
  - All 8 words are then delivered with no loss or duplication.
- FIFO empty, `en`=1 for 20 cycles:
  - `rd_en`=0 throughout; `underflow` never asserts; `err_underflow`=0; `busy`=1.
- Deassert `en` with 2 words buffered and 1 inflight:
  - State goes to DRAIN; 3 more words are delivered; no further `rd_en`.
  - State reaches IDLE with `busy`=0.
  - 5 more words, `en`=1: `out_last` lands on word 8 of the frame (`beat` preserved).
- Pulse `rst_n`=0 with `occ`=2:
  - Next cycle: `out_valid`=0, `word_cnt`=0, `busy`=0; buffered data is not emitted.
- Force `underflow`=1 for one cycle:
  - `err_underflow`=1 and stays set until `clr_err`.
  - `clr_err` and `underflow` together → remains 1.
